// File: rtl/serial_word_receiver.sv
// serial_word_receiver
//   Serial-in, parallel-out receiver for an LSB-first bit stream. A start-of-frame
//   marker (i_sof) aligns the word boundary. Each completed N-bit word is presented
//   on a valid/ready port. Dropped words raise a sticky overrun flag, and a sof
//   arriving mid-word raises a sticky frame error flag.
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   i_en              bit strobe; i_sof / i_si are sampled only when high
//   i_sof             marks the current i_si as bit 0 of a new word
//   i_si              serial data, LSB first
//   i_out_ready       downstream accepts o_out_data while o_out_valid=1
//   i_clr_err         synchronous clear of o_overrun / o_frame_err
//   o_out_data[N-1:0] last completed word (held while o_out_valid=1)
//   o_out_valid       o_out_data holds an unconsumed word
//   o_busy            a word is partially received
//   o_overrun         sticky: a completed word was dropped
//   o_frame_err       sticky: sof arrived mid-word
module serial_word_receiver #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_sof,
  input  logic         i_si,
  input  logic         i_out_ready,
  input  logic         i_clr_err,
  output logic [N-1:0] o_out_data,
  output logic         o_out_valid,
  output logic         o_busy,
  output logic         o_overrun,
  output logic         o_frame_err
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_sr;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_accept, w_done, w_abort;
  logic [N-1:0]  w_word;
  logic          w_drop;

  // Word as it stands after shifting in the current bit.
  assign w_word = {i_si, r_sr[N-1:1]};

  // A completed word is dropped only if the holding register stays occupied.
  assign w_drop = w_done & o_out_valid & ~i_out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) r_sr <= w_word;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Bits outside a frame are ignored until a sof shows up.
        if (i_en && i_sof) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = S_RECV;
        end
      end
      S_RECV: begin
        if (i_en) begin
          w_accept = 1'b1;
          if (i_sof) begin
            // Restart: the partial word is abandoned, this bit is bit 0.
            w_abort   = 1'b1;
            w_cnt_nxt = CW'(1);
          end else if (r_cnt == CW'(N - 1)) begin
            w_done      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_out_data  <= '0;
      o_out_valid <= 1'b0;
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      if (w_done && !w_drop) begin
        o_out_data  <= w_word;
        o_out_valid <= 1'b1;
      end else if (o_out_valid && i_out_ready) begin
        o_out_valid <= 1'b0;
      end
      // Error events take priority over a same-cycle clear.
      if (w_drop)         o_overrun <= 1'b1;
      else if (i_clr_err) o_overrun <= 1'b0;
      if (w_abort)        o_frame_err <= 1'b1;
      else if (i_clr_err) o_frame_err <= 1'b0;
    end
  end

  assign o_busy = (r_state == S_RECV);

endmodule

// File: tb/tb_serial_word_receiver.sv
module tb_serial_word_receiver;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_en = 1'b0, i_sof = 1'b0, i_si = 1'b0;
  logic         i_out_ready = 1'b0, i_clr_err = 1'b0;
  logic [N-1:0] o_out_data;
  logic         o_out_valid, o_busy, o_overrun, o_frame_err;

  int n_chk  = 0;
  int n_pass = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] tx_sr;

  serial_word_receiver #(.N(N)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_sof(i_sof), .i_si(i_si),
    .i_out_ready(i_out_ready), .i_clr_err(i_clr_err),
    .o_out_data(o_out_data), .o_out_valid(o_out_valid), .o_busy(o_busy),
    .o_overrun(o_overrun), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic en, input logic sof, input logic si);
    i_en = en; i_sof = sof; i_si = si;
    @(posedge clk);
    #1;
    i_clr_err = 1'b0;
  endtask

  task automatic send_word(input logic [N-1:0] w, input bit expect_out);
    if (expect_out) exp_q.push_back(w);
    for (int i = 0; i < N; i++) cyc(1'b1, i == 0, w[i]);
    i_en = 1'b0; i_sof = 1'b0;
  endtask

  // Right-shift transmitter: serial output is its LSB, shifted each enabled cycle.
  task automatic loopback(input logic [N-1:0] w);
    tx_sr = w;
    exp_q.push_back(w);
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, i == 0, tx_sr[0]);
      tx_sr = {1'b0, tx_sr[N-1:1]};
    end
    i_en = 1'b0; i_sof = 1'b0;
  endtask

  task automatic chk_word(input string tag);
    logic [N-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, o_out_data, e);
      chk({tag, "_valid"}, o_out_valid, 1);
    end
  endtask

  initial begin
    #12;
    chk("rst_data", o_out_data, 0);
    chk("rst_valid", o_out_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_overrun", o_overrun, 0);
    chk("rst_frame_err", o_frame_err, 0);
    rst = 1'b0;

    // Bits without sof in IDLE are ignored.
    cyc(1, 0, 1); cyc(1, 0, 0);
    chk("idle_ignore_busy", o_busy, 0);
    chk("idle_ignore_valid", o_out_valid, 0);

    // Basic word 1,0,1,1 -> 4'hD with busy profile.
    i_out_ready = 1'b1;
    exp_q.push_back(4'hD);
    cyc(1, 1, 1); chk("basic_busy1", o_busy, 1);
    cyc(1, 0, 0); chk("basic_busy2", o_busy, 1);
    cyc(1, 0, 1); chk("basic_busy3", o_busy, 1);
    cyc(1, 0, 1); chk("basic_busy4", o_busy, 0);
    chk_word("basic");
    cyc(0, 0, 0); chk("basic_consumed", o_out_valid, 0);

    // Loopback from the shift transmitter, back-to-back words.
    loopback(4'hA); chk_word("lb_A");
    loopback(4'h0); chk_word("lb_0");
    loopback(4'hF); chk_word("lb_F");
    loopback(4'h5); chk_word("lb_5");
    cyc(0, 0, 0); chk("lb_consumed", o_out_valid, 0);

    // Backpressure and overrun.
    i_out_ready = 1'b0;
    send_word(4'h3, 1);
    send_word(4'hC, 0);
    chk_word("ovr");
    chk("ovr_flag", o_overrun, 1);
    i_out_ready = 1'b1;
    cyc(0, 0, 0); chk("ovr_consume", o_out_valid, 0);
    chk("ovr_data_kept", o_out_data, 4'h3);
    i_out_ready = 1'b0;
    i_clr_err = 1'b1;
    cyc(0, 0, 0); chk("ovr_clear", o_overrun, 0);

    // Simultaneous consume and complete on the final bit of 4'h6.
    send_word(4'h9, 1);
    chk_word("sim_pre");
    exp_q.push_back(4'h6);
    cyc(1, 1, 0); cyc(1, 0, 1); cyc(1, 0, 1);
    i_out_ready = 1'b1;
    cyc(1, 0, 0);
    chk_word("sim");
    chk("sim_no_overrun", o_overrun, 0);
    cyc(0, 0, 0); chk("sim_consumed", o_out_valid, 0);

    // Framing error with en=0 gaps; clr_err coincident with the abort loses.
    cyc(1, 1, 1);
    cyc(0, 1, 1);
    cyc(1, 0, 0);
    i_clr_err = 1'b1;
    exp_q.push_back(4'hE);
    cyc(1, 1, 0);
    chk("frm_flag_wins", o_frame_err, 1);
    chk("frm_busy", o_busy, 1);
    cyc(0, 0, 1);
    cyc(1, 0, 1);
    cyc(0, 1, 0);
    cyc(1, 0, 1);
    chk("frm_partial_hidden", o_out_valid, 0);
    cyc(1, 0, 1);
    chk_word("frm");
    i_clr_err = 1'b1;
    cyc(0, 0, 0);
    chk("frm_clear", o_frame_err, 0);

    // Reset mid-word while a word is held.
    i_out_ready = 1'b0;
    send_word(4'h5, 1);
    chk_word("rstmid_pre");
    cyc(1, 1, 1); cyc(1, 0, 1);
    i_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rstmid_data", o_out_data, 0);
    chk("rstmid_valid", o_out_valid, 0);
    chk("rstmid_busy", o_busy, 0);
    chk("rstmid_overrun", o_overrun, 0);
    chk("rstmid_frame_err", o_frame_err, 0);
    exp_q.delete();
    #1 rst = 1'b0;
    i_out_ready = 1'b1;
    send_word(4'h7, 1);
    chk_word("rstmid_after");
    chk("rstmid_after_frame_err", o_frame_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
